ring_counter_seq: RTL and testbench

- Test/run sequencer for the 200-bit left/right ring counter and its loopback checker.
- On a start command it parks and seeds the counter, then steps it in a programmed direction pattern.
- It drives the counter's reset, lr, loopback_en and counter_in, and counts loopback mismatches.
- It sits beside the counter in the ring-counter test harness and reports pass/fail plus first-failure step to the host/JTAG status logic.

---
 rtl/ring_counter_seq.sv | 171 +++++++++++++++++
 tb/tb_ring_counter_seq.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ring_counter_seq.sv
// Run sequencer for the WIDTH-bit left/right ring counter and its loopback checker.
// Parks and seeds the counter, steps it in a direction pattern, and counts mismatches.
module ring_counter_seq #(
    parameter int WIDTH  = 200,
    parameter int STEP_W = 16,
    parameter int ERR_W  = 8
) (
    input  logic              clock0,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        mode,
    input  logic [STEP_W-1:0] num_steps,
    output logic              rc_reset,
    output logic              rc_lr,
    output logic              rc_loopback_en,
    output logic [WIDTH-1:0]  rc_expected,
    input  logic              rc_loopback_error,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              aborted,
    output logic [ERR_W-1:0]  err_count,
    output logic [STEP_W-1:0] first_err_step
);

    localparam logic [WIDTH-1:0]  SEED    = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [STEP_W:0]   K_ONE   = 1;
    localparam logic [ERR_W-1:0]  ERR_ONE = 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          mode_q, mode_d;
    logic [STEP_W-1:0]   nsteps_q, nsteps_d;
    logic [STEP_W:0]     k_q, k_d;
    logic [WIDTH-1:0]    model_q, model_d;
    logic [ERR_W-1:0]    err_q, err_d;
    logic [STEP_W-1:0]   first_q, first_d;
    logic                pass_q, pass_d;
    logic                aborted_q, aborted_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic                rst_q, rst_d;
    logic                lben_q, lben_d;
    logic                lr_q, lr_d;
    logic                cur_dir;
    logic                last;

    // 1 = shift left; alternate mode starts left on even steps
    function automatic logic dir_f(input logic [1:0] m, input logic k0);
        logic d;
        case (m)
            2'b01:   d = 1'b0;
            2'b10:   d = ~k0;
            default: d = 1'b1;
        endcase
        return d;
    endfunction

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        nsteps_d  = nsteps_q;
        k_d       = k_q;
        model_d   = model_q;
        err_d     = err_q;
        first_d   = first_q;
        pass_d    = pass_q;
        aborted_d = aborted_q;
        cur_dir   = dir_f(mode_q, k_q[0]);
        last      = (k_q == {1'b0, nsteps_q});

        unique case (state_q)
            S_IDLE: begin
                model_d = SEED;
                if (start) begin
                    mode_d    = mode;
                    nsteps_d  = num_steps;
                    err_d     = '0;
                    first_d   = '0;
                    pass_d    = 1'b0;
                    aborted_d = 1'b0;
                    k_d       = '0;
                    state_d   = S_RUN;
                end
            end
            S_RUN: begin
                if (rc_loopback_error) begin
                    if (err_q != '1) err_d = err_q + ERR_ONE;
                    if (err_q == '0) first_d = k_q[STEP_W-1:0];
                end
                model_d = cur_dir ? {model_q[WIDTH-2:0], model_q[WIDTH-1]}
                                  : {model_q[0], model_q[WIDTH-1:1]};
                k_d = k_q + K_ONE;
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = S_DONE;
                end else if (last) begin
                    state_d = S_DONE;
                end
                if (state_d == S_DONE) begin
                    model_d = SEED;
                    k_d     = '0;
                    pass_d  = (err_d == '0) && !aborted_d;
                end
            end
            S_DONE: begin
                model_d = SEED;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        rst_d  = (state_d != S_RUN);
        lben_d = (state_d == S_RUN);
        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
        lr_d   = (state_d == S_RUN) ? dir_f(mode_d, k_d[0]) : 1'b1;
    end

    always_ff @(posedge clock0 or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            mode_q    <= 2'b00;
            nsteps_q  <= '0;
            k_q       <= '0;
            model_q   <= SEED;
            err_q     <= '0;
            first_q   <= '0;
            pass_q    <= 1'b0;
            aborted_q <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            rst_q     <= 1'b1;
            lben_q    <= 1'b0;
            lr_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            nsteps_q  <= nsteps_d;
            k_q       <= k_d;
            model_q   <= model_d;
            err_q     <= err_d;
            first_q   <= first_d;
            pass_q    <= pass_d;
            aborted_q <= aborted_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            rst_q     <= rst_d;
            lben_q    <= lben_d;
            lr_q      <= lr_d;
        end
    end

    assign rc_reset       = rst_q;
    assign rc_lr          = lr_q;
    assign rc_loopback_en = lben_q;
    assign rc_expected    = model_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign aborted        = aborted_q;
    assign err_count      = err_q;
    assign first_err_step = first_q;

endmodule

// File: tb/tb_ring_counter_seq.sv
// Directed bench for ring_counter_seq: runs, alternation, errors, abort, reset.
module tb_ring_counter_seq;

    localparam int W  = 200;
    localparam int SW = 16;
    localparam int EW = 8;

    typedef logic [W-1:0] vec_t;

    logic          clock0 = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic [1:0]    mode;
    logic [SW-1:0] num_steps;
    logic          rc_reset;
    logic          rc_lr;
    logic          rc_loopback_en;
    logic [W-1:0]  rc_expected;
    logic          rc_loopback_error;
    logic          busy;
    logic          done;
    logic          pass;
    logic          aborted;
    logic [EW-1:0] err_count;
    logic [SW-1:0] first_err_step;

    int checks = 0;
    int errors = 0;

    vec_t seed;

    ring_counter_seq #(.WIDTH(W), .STEP_W(SW), .ERR_W(EW)) dut (
        .clock0            (clock0),
        .reset             (reset),
        .start             (start),
        .abort             (abort),
        .mode              (mode),
        .num_steps         (num_steps),
        .rc_reset          (rc_reset),
        .rc_lr             (rc_lr),
        .rc_loopback_en    (rc_loopback_en),
        .rc_expected       (rc_expected),
        .rc_loopback_error (rc_loopback_error),
        .busy              (busy),
        .done              (done),
        .pass              (pass),
        .aborted           (aborted),
        .err_count         (err_count),
        .first_err_step    (first_err_step)
    );

    always #5 clock0 = ~clock0;

    task automatic check(input string tag, input vec_t got, input vec_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock0);
        @(negedge clock0);
    endtask

    function automatic vec_t bitv(input int n);
        vec_t v;
        v = vec_t'(1) << n;
        return v;
    endfunction

    // pulse start; returns at the sample point of step k=0
    task automatic go(input logic [1:0] m, input int n);
        start     = 1'b1;
        mode      = m;
        num_steps = SW'(n);
        cyc();
        start     = 1'b0;
    endtask

    task automatic chk_done(input string tag, input logic exp_pass);
        check({tag, "_done"}, vec_t'(done), vec_t'(1));
        check({tag, "_busy"}, vec_t'(busy), vec_t'(0));
        check({tag, "_pass"}, vec_t'(pass), vec_t'(exp_pass));
        check({tag, "_rcrst"}, vec_t'(rc_reset), vec_t'(1));
        check({tag, "_lben"}, vec_t'(rc_loopback_en), vec_t'(0));
    endtask

    initial begin
        seed              = bitv(W-1);
        reset             = 1'b0;
        start             = 1'b0;
        abort             = 1'b0;
        mode              = 2'b00;
        num_steps         = '0;
        rc_loopback_error = 1'b0;
        cyc();
        cyc();
        check("rst_rcrst", vec_t'(rc_reset), vec_t'(1));
        check("rst_lr", vec_t'(rc_lr), vec_t'(1));
        check("rst_lben", vec_t'(rc_loopback_en), vec_t'(0));
        check("rst_exp", rc_expected, seed);
        check("rst_busy", vec_t'(busy), vec_t'(0));
        check("rst_done", vec_t'(done), vec_t'(0));
        check("rst_pass", vec_t'(pass), vec_t'(0));
        check("rst_err", vec_t'(err_count), vec_t'(0));
        reset = 1'b1;
        cyc();

        // left, 5 steps
        go(2'b00, 5);
        check("l_busy", vec_t'(busy), vec_t'(1));
        check("l_rcrst", vec_t'(rc_reset), vec_t'(0));
        check("l_lben", vec_t'(rc_loopback_en), vec_t'(1));
        for (int k = 0; k <= 5; k++) begin
            check($sformatf("l_exp%0d", k), rc_expected,
                  (k == 0) ? seed : bitv(k-1));
            check($sformatf("l_lr%0d", k), vec_t'(rc_lr), vec_t'(1));
            cyc();
        end
        chk_done("l", 1'b1);
        check("l_err", vec_t'(err_count), vec_t'(0));
        cyc();
        check("l_pulse", vec_t'(done), vec_t'(0));
        check("l_hold", vec_t'(pass), vec_t'(1));

        // right, full wrap
        go(2'b01, 200);
        for (int k = 0; k <= 200; k++) begin
            if (k == 1) begin
                check("r_exp1", rc_expected, bitv(198));
                check("r_lr1", vec_t'(rc_lr), vec_t'(0));
            end
            if (k == 200) check("r_exp200", rc_expected, seed);
            cyc();
        end
        chk_done("r", 1'b1);
        cyc();

        // alternate
        go(2'b10, 4);
        for (int k = 0; k <= 4; k++) begin
            check($sformatf("a_exp%0d", k), rc_expected,
                  (k % 2 == 0) ? seed : bitv(0));
            check($sformatf("a_lr%0d", k), vec_t'(rc_lr),
                  vec_t'((k % 2 == 0) ? 1 : 0));
            cyc();
        end
        chk_done("a", 1'b1);
        cyc();

        // errors at k=3 and k=7
        go(2'b00, 10);
        for (int k = 0; k <= 10; k++) begin
            rc_loopback_error = (k == 3 || k == 7);
            cyc();
        end
        rc_loopback_error = 1'b0;
        chk_done("e", 1'b0);
        check("e_cnt", vec_t'(err_count), vec_t'(2));
        check("e_first", vec_t'(first_err_step), vec_t'(3));
        cyc();
        check("e_holdcnt", vec_t'(err_count), vec_t'(2));

        // saturation
        rc_loopback_error = 1'b1;
        go(2'b00, 299);
        repeat (300) cyc();
        rc_loopback_error = 1'b0;
        chk_done("s", 1'b0);
        check("s_cnt", vec_t'(err_count), vec_t'(255));
        check("s_first", vec_t'(first_err_step), vec_t'(0));
        cyc();

        // abort at k=2 with an error in the same cycle
        go(2'b00, 50);
        cyc();
        cyc();
        abort             = 1'b1;
        rc_loopback_error = 1'b1;
        cyc();
        abort             = 1'b0;
        rc_loopback_error = 1'b0;
        chk_done("ab", 1'b0);
        check("ab_flag", vec_t'(aborted), vec_t'(1));
        check("ab_cnt", vec_t'(err_count), vec_t'(1));
        check("ab_first", vec_t'(first_err_step), vec_t'(2));
        cyc();
        abort = 1'b1;
        cyc();
        check("ab_idle", vec_t'(busy), vec_t'(0));
        start     = 1'b1;
        mode      = 2'b00;
        num_steps = SW'(3);
        cyc();
        start = 1'b0;
        abort = 1'b0;
        check("sw_busy", vec_t'(busy), vec_t'(1));
        check("sw_abclr", vec_t'(aborted), vec_t'(0));
        cyc();
        start     = 1'b1;
        num_steps = SW'(40);
        cyc();
        start = 1'b0;
        check("sw_k2", rc_expected, bitv(1));
        cyc();
        check("sw_k3", rc_expected, bitv(2));
        cyc();
        chk_done("sw", 1'b1);
        cyc();

        // async reset mid-run
        go(2'b00, 50);
        repeat (20) cyc();
        check("mr_exp20", rc_expected, bitv(19));
        reset = 1'b0;
        #1;
        check("mr_rcrst", vec_t'(rc_reset), vec_t'(1));
        check("mr_busy", vec_t'(busy), vec_t'(0));
        check("mr_exp", rc_expected, seed);
        check("mr_lben", vec_t'(rc_loopback_en), vec_t'(0));
        for (int i = 0; i < 3; i++) begin
            cyc();
            check($sformatf("mr_nodone%0d", i), vec_t'(done), vec_t'(0));
        end
        reset = 1'b1;
        cyc();
        go(2'b00, 2);
        check("pr_k0", rc_expected, seed);
        cyc();
        check("pr_k1", rc_expected, bitv(0));
        cyc();
        check("pr_k2", rc_expected, bitv(1));
        cyc();
        chk_done("pr", 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
